// File: rtl/led_pattern_engine.sv
// LED animation engine: divider-paced rotate, ping-pong, bar, flash, hold and off modes
// with pause, single-step and seed load. Define PATTERN_LFSR_EN to make mode 110 a Galois LFSR.
module led_pattern_engine #(
  parameter int                WIDTH     = 8,
  parameter int                DIV_W     = 22,
  parameter logic [WIDTH-1:0]  LFSR_TAPS = WIDTH'(8'hB8)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic [2:0]       speed,
  input  logic             pause,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] led,
  output logic             dir,
  output logic             step_o
);

  localparam logic [2:0] MODE_ROL   = 3'b000;
  localparam logic [2:0] MODE_ROR   = 3'b001;
  localparam logic [2:0] MODE_PING  = 3'b010;
  localparam logic [2:0] MODE_BAR   = 3'b011;
  localparam logic [2:0] MODE_FLASH = 3'b100;
  localparam logic [2:0] MODE_HOLD  = 3'b101;
  localparam logic [2:0] MODE_LFSR  = 3'b110;
  localparam logic [2:0] MODE_OFF   = 3'b111;

`ifdef PATTERN_LFSR_EN
  localparam bit LFSR_ON = 1'b1;
`else
  localparam bit LFSR_ON = 1'b0;
`endif

  if (WIDTH < 4 || WIDTH > 32) begin : g_chk_width
    $error("led_pattern_engine: WIDTH must be within 4..32");
  end
  if (DIV_W < 4) begin : g_chk_div
    $error("led_pattern_engine: DIV_W must be at least 4");
  end
  if (LFSR_TAPS == '0) begin : g_chk_taps
    $error("led_pattern_engine: LFSR_TAPS must be nonzero");
  end

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] tick_mask;
  logic [2:0]       mode_p1;
  logic             step_p1;
  logic             tick_p0;
  logic             mode_chg_p0;
  logic             step_rise_p0;
  logic             adv_p0;
  logic             off_p0;
  logic             vld_p0;
  logic [WIDTH-1:0] pat_nxt;
  logic             dir_nxt;
  logic [WIDTH:0]   ping_nxt;
  logic [WIDTH:0]   bar_nxt;

  // Speed saturates so the tick window never collapses below bit 0.
  function automatic logic [2:0] sat_speed(input logic [2:0] sp);
    if (int'(sp) > DIV_W - 1)
      return 3'(DIV_W - 1);
    else
      return sp;
  endfunction

  function automatic logic [WIDTH-1:0] start_val(input logic [2:0]       m,
                                                 input logic [WIDTH-1:0] cur);
    case (m)
      MODE_BAR,
      MODE_OFF:  return '0;
      MODE_HOLD: return cur;
      MODE_LFSR: return LFSR_ON ? WIDTH'(1) : '0;
      default:   return WIDTH'(1);
    endcase
  endfunction

  // Returns {dir, pattern}; a block of set bits reverses once it touches either end.
  function automatic logic [WIDTH:0] ping_f(input logic d, input logic [WIDTH-1:0] p);
    if (!d) begin
      if (p[WIDTH-1]) return {1'b1, p >> 1};
      else            return {1'b0, p << 1};
    end else begin
      if (p[0])       return {1'b0, p << 1};
      else            return {1'b1, p >> 1};
    end
  endfunction

  function automatic logic [WIDTH:0] bar_f(input logic d, input logic [WIDTH-1:0] p);
    logic [WIDTH-1:0] n;
    if (!d) begin
      n = {p[WIDTH-2:0], 1'b1};
      return {(&n), n};
    end else begin
      n = p >> 1;
      return {(n != '0), n};
    end
  endfunction

`ifdef PATTERN_LFSR_EN
  // All-zero would lock the register up, so it restarts from 1.
  function automatic logic [WIDTH-1:0] lfsr_f(input logic [WIDTH-1:0] p);
    if (p == '0)
      return WIDTH'(1);
    else
      return (p >> 1) ^ (p[0] ? LFSR_TAPS : '0);
  endfunction
`endif

  // Stage p0: tick, edge detect and next-pattern selection
  always_comb begin
    tick_mask    = {DIV_W{1'b1}} >> sat_speed(speed);
    tick_p0      = &(div_cnt | ~tick_mask);
    mode_chg_p0  = (mode != mode_p1);
    step_rise_p0 = step & ~step_p1;
    adv_p0       = (tick_p0 & ~pause) | step_rise_p0;
    off_p0       = (mode == MODE_OFF) || (!LFSR_ON && (mode == MODE_LFSR));
    ping_nxt     = ping_f(dir, led);
    bar_nxt      = bar_f(dir, led);
  end

  always_comb begin
    pat_nxt = led;
    dir_nxt = dir;
    vld_p0  = 1'b0;
    if (load) begin
      pat_nxt = seed;
      dir_nxt = 1'b0;
    end else if (mode_chg_p0) begin
      pat_nxt = start_val(mode, led);
      dir_nxt = 1'b0;
    end else if (off_p0) begin
      pat_nxt = '0;
    end else if (adv_p0) begin
      vld_p0 = 1'b1;
      case (mode)
        MODE_ROL:   pat_nxt = {led[WIDTH-2:0], led[WIDTH-1]};
        MODE_ROR:   pat_nxt = {led[0], led[WIDTH-1:1]};
        MODE_PING:  {dir_nxt, pat_nxt} = ping_nxt;
        MODE_BAR:   {dir_nxt, pat_nxt} = bar_nxt;
        MODE_FLASH: pat_nxt = ~led;
`ifdef PATTERN_LFSR_EN
        MODE_LFSR:  pat_nxt = lfsr_f(led);
`endif
        default:    pat_nxt = led;
      endcase
    end
  end

  // Stage p1: pattern register, divider and strobe
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      mode_p1 <= MODE_ROL;
      step_p1 <= 1'b0;
      led     <= WIDTH'(1);
      dir     <= 1'b0;
      step_o  <= 1'b0;
    end else begin
      div_cnt <= mode_chg_p0 ? '0 : div_cnt + DIV_W'(1);
      mode_p1 <= mode;
      step_p1 <= step;
      led     <= pat_nxt;
      dir     <= dir_nxt;
      step_o  <= vld_p0;
    end
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Scoreboard bench for led_pattern_engine at WIDTH=8, DIV_W=4: stimulus queues expected
// {dir, led} per advance, the monitor checks each step_o strobe against the queue.
module tb_led_pattern_engine;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] mode;
  logic [2:0] speed;
  logic       pause;
  logic       step;
  logic       load;
  logic [7:0] seed;
  logic [7:0] led;
  logic       dir;
  logic       step_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int strobes  = 0;
  int last_cyc = 0;
  int prev_cyc = 0;
  bit sb_ignore = 1'b0;
  logic [8:0] exp_q[$];

  always #5 clock = ~clock;

  led_pattern_engine #(.WIDTH(8), .DIV_W(4)) dut (
    .clock  (clock),
    .reset  (reset),
    .mode   (mode),
    .speed  (speed),
    .pause  (pause),
    .step   (step),
    .load   (load),
    .seed   (seed),
    .led    (led),
    .dir    (dir),
    .step_o (step_o)
  );

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    logic [8:0] e;
    forever begin
      @(posedge clock);
      #1;
      if (step_o === 1'b1) begin
        strobes  = strobes + 1;
        prev_cyc = last_cyc;
        last_cyc = cyc;
        if (!sb_ignore) begin
          checks = checks + 1;
          if (exp_q.size() == 0) begin
            failures = failures + 1;
            $display("FAIL unexpected_strobe#%0d got dir=%b led=%h, queue empty", strobes, dir, led);
          end else begin
            e = exp_q.pop_front();
            if ({dir, led} !== e) begin
              failures = failures + 1;
              $display("FAIL strobe#%0d got dir=%b led=%h expected dir=%b led=%h",
                       strobes, dir, led, e[8], e[7:0]);
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic push(input logic d, input logic [7:0] v);
    exp_q.push_back({d, v});
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int target;
    target = strobes + n;
    for (int i = 0; i < budget && strobes < target; i++) @(negedge clock);
    check("strobe_count", strobes, target);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge clock);
    step = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    int s0;
    int chg;
    logic [7:0] v;
    #500000;
    $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int chg;
    logic [7:0] v;
    reset = 1'b1; mode = 3'b000; speed = 3'd0; pause = 1'b1;
    step = 1'b0; load = 1'b0; seed = 8'h00;
    repeat (3) @(negedge clock);
    check("reset_led", led, 8'h01);
    check("reset_dir", dir, 1'b0);
    check("reset_step_o", step_o, 1'b0);
    reset = 1'b0;

    // Scenario 1: rotate left
    @(negedge clock);
    pause = 1'b0;
    for (int i = 1; i < 8; i++) push(1'b0, 8'(1 << i));
    push(1'b0, 8'h01);
    wait_strobes(8, 300);
    pause = 1'b1;
    check("tick_period_spd0", last_cyc - prev_cyc, 16);

    // Scenario 2: ping-pong
    mode = 3'b010;
    @(negedge clock);
    check("ping_start_led", led, 8'h01);
    check("ping_start_dir", dir, 1'b0);
    pause = 1'b0;
    for (int i = 1; i < 8; i++) push(1'b0, 8'(1 << i));
    for (int i = 6; i >= 0; i--) push(1'b1, 8'(1 << i));
    push(1'b0, 8'h02);
    wait_strobes(15, 500);
    pause = 1'b1;

    // Scenario 3: bar fill/drain, then reset mid-animation
    mode = 3'b011;
    @(negedge clock);
    check("bar_start_led", led, 8'h00);
    pause = 1'b0;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      v = {v[6:0], 1'b1};
      push(i == 7, v);
    end
    for (int i = 0; i < 8; i++) begin
      v = v >> 1;
      push(v != 8'h00, v);
    end
    push(1'b0, 8'h01);
    wait_strobes(17, 600);
    push(1'b0, 8'h03); push(1'b0, 8'h07); push(1'b0, 8'h0F);
    push(1'b0, 8'h1F); push(1'b0, 8'h3F);
    wait_strobes(5, 200);
    check("bar_before_reset", led, 8'h3F);
    reset = 1'b1; mode = 3'b000; pause = 1'b1;
    #1;
    check("midreset_led", led, 8'h01);
    check("midreset_dir", dir, 1'b0);
    check("midreset_step_o", step_o, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    // Scenario 4: pause freeze, held step, step coincident with tick, load over adv
    s0 = strobes;
    repeat (64) @(negedge clock);
    check("pause_frozen_led", led, 8'h01);
    check("pause_no_strobe", strobes, s0);
    step = 1'b1;
    push(1'b0, 8'h02);
    repeat (5) @(negedge clock);
    step = 1'b0;
    repeat (3) @(negedge clock);
    check("held_step_one_adv", strobes, s0 + 1);
    check("held_step_led", led, 8'h02);

    mode = 3'b001;
    @(negedge clock);
    check("modechg_led", led, 8'h01);
    repeat (15) @(negedge clock);
    step = 1'b1; pause = 1'b0;
    push(1'b0, 8'h80);
    @(negedge clock);
    pause = 1'b1;
    repeat (4) @(negedge clock);
    step = 1'b0;
    @(negedge clock);
    check("coincident_one_adv", strobes, s0 + 2);
    check("coincident_led", led, 8'h80);

    sb_ignore = 1'b1;
    step = 1'b1; load = 1'b1; seed = 8'hA5;
    @(negedge clock);
    load = 1'b0;
    check("load_led", led, 8'hA5);
    check("load_dir", dir, 1'b0);
    repeat (2) @(negedge clock);
    step = 1'b0;
    @(negedge clock);
    sb_ignore = 1'b0;
    push(1'b0, 8'hD2);
    pulse_step();
    check("after_load_ror", led, 8'hD2);

    // Scenario 5: speed select and mode change mid-period
    mode = 3'b000;
    @(negedge clock);
    check("rol_restart_led", led, 8'h01);
    speed = 3'd3; pause = 1'b0;
    push(1'b0, 8'h02); push(1'b0, 8'h04); push(1'b0, 8'h08);
    wait_strobes(3, 50);
    pause = 1'b1;
    check("tick_period_spd3", last_cyc - prev_cyc, 2);
    speed = 3'd7; pause = 1'b0;
    push(1'b0, 8'h10); push(1'b0, 8'h20); push(1'b0, 8'h40);
    wait_strobes(3, 50);
    pause = 1'b1;
    check("tick_period_spd7", last_cyc - prev_cyc, 2);
    speed = 3'd0; pause = 1'b0;
    push(1'b0, 8'h80);
    wait_strobes(1, 40);
    repeat (5) @(negedge clock);
    mode = 3'b001;
    chg = cyc + 1;
    @(negedge clock);
    check("midperiod_chg_led", led, 8'h01);
    push(1'b0, 8'h80);
    wait_strobes(1, 40);
    pause = 1'b1;
    check("midperiod_chg_delay", last_cyc - chg, 16);

    // Complement flash and hold
    mode = 3'b100;
    @(negedge clock);
    load = 1'b1; seed = 8'h3C;
    @(negedge clock);
    load = 1'b0;
    check("flash_seed", led, 8'h3C);
    push(1'b0, 8'hC3);
    pulse_step();
    push(1'b0, 8'h3C);
    pulse_step();
    mode = 3'b101;
    @(negedge clock);
    check("hold_keeps_led", led, 8'h3C);
    push(1'b0, 8'h3C);
    pulse_step();

    // Off mode
    mode = 3'b111;
    s0 = strobes;
    pause = 1'b0;
    repeat (40) @(negedge clock);
    pulse_step();
    pause = 1'b1;
    check("off_led", led, 8'h00);
    check("off_no_strobe", strobes, s0);

    // Scenario 6: mode 110
`ifdef PATTERN_LFSR_EN
    mode = 3'b110;
    @(negedge clock);
    check("lfsr_start", led, 8'h01);
    pause = 1'b0;
    push(1'b0, 8'hB8); push(1'b0, 8'h5C); push(1'b0, 8'h2E);
    push(1'b0, 8'h17); push(1'b0, 8'hB3);
    wait_strobes(5, 200);
    pause = 1'b1;
    load = 1'b1; seed = 8'h00;
    @(negedge clock);
    load = 1'b0;
    check("lfsr_zero_seed", led, 8'h00);
    push(1'b0, 8'h01);
    pulse_step();
    check("lfsr_escape", led, 8'h01);
    sb_ignore = 1'b1;
    speed = 3'd3; pause = 1'b0;
    wait_strobes(255, 1500);
    pause = 1'b1; speed = 3'd0;
    repeat (2) @(negedge clock);
    sb_ignore = 1'b0;
    check("lfsr_period_255", led, 8'h01);
`else
    mode = 3'b110;
    @(negedge clock);
    s0 = strobes;
    pause = 1'b0;
    repeat (40) @(negedge clock);
    pulse_step();
    pause = 1'b1;
    check("lfsr_off_led", led, 8'h00);
    check("lfsr_off_no_strobe", strobes, s0);
`endif

    repeat (5) @(negedge clock);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
